dbg_jtag_tap: RTL and testbench

JTAG TAP controller and Debug Transport Module front end for the RISC-V debug module. It sits directly downstream of the JTAG pin driver, either the simulation DPI driver or the chip pads. It consumes TCK/TMS/TDI/TRSTn and returns TDO plus a TDO-driven flag. It decodes the 16-state IEEE 1149.1 TAP and provides IDCODE, BYPASS, DTMCS and DMI data registers. Each DMI Update-DR is converted into a single-cycle request toward the DMI/CDC stage.

---
 rtl/dbg_jtag_tap.sv | 167 ++++++++++++++++
 tb/tb_dbg_jtag_tap.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dbg_jtag_tap.sv
// JTAG TAP controller with IDCODE/BYPASS/DTMCS/DMI data registers.
// Turns each accepted DMI Update-DR into a single-cycle request toward the DMI/CDC stage.
module dbg_jtag_tap #(
  parameter int unsigned IrLength = 5,
  parameter logic [31:0] IdCode   = 32'h0000_0DB3,
  parameter int unsigned DmiAbits = 7
) (
  input  logic                tck_i,
  input  logic                trst_ni,
  input  logic                tms_i,
  input  logic                tdi_i,
  output logic                tdo_o,
  output logic                tdo_oe_o,
  output logic                dmi_req_valid_o,
  output logic [DmiAbits-1:0] dmi_req_addr_o,
  output logic [31:0]         dmi_req_data_o,
  output logic [1:0]          dmi_req_op_o,
  input  logic                dmi_busy_i,
  input  logic [31:0]         dmi_resp_data_i,
  input  logic                dmi_resp_err_i,
  output logic                dmi_reset_o,
  output logic [3:0]          tap_state_o
);

  localparam int unsigned DrW = DmiAbits + 34;
  localparam logic [IrLength-1:0] IrIdcode = IrLength'(32'h01);
  localparam logic [IrLength-1:0] IrDtmcs  = IrLength'(32'h10);
  localparam logic [IrLength-1:0] IrDmi    = IrLength'(32'h11);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {SEL_IDCODE, SEL_DTMCS, SEL_DMI, SEL_BYPASS} dr_sel_e;

  tap_state_e            state_q, state_d;
  dr_sel_e               dr_sel;
  logic [IrLength-1:0]   ir_q, ir_sr_q;
  logic [DrW-1:0]        dr_sr_q;
  logic [1:0]            dmistat_q;
  logic [DmiAbits-1:0]   last_addr_q;
  logic [31:0]           dtmcs_cap;
  logic [1:0]            dmi_cap_op;
  logic [1:0]            upd_op;

  assign tap_state_o = state_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = tms_i ? TLR      : RTI;
      RTI:      state_d = tms_i ? SEL_DR   : RTI;
      SEL_DR:   state_d = tms_i ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = tms_i ? EX1_DR   : SH_DR;
      SH_DR:    state_d = tms_i ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = tms_i ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = tms_i ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = tms_i ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = tms_i ? SEL_DR   : RTI;
      SEL_IR:   state_d = tms_i ? TLR      : CAP_IR;
      CAP_IR:   state_d = tms_i ? EX1_IR   : SH_IR;
      SH_IR:    state_d = tms_i ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = tms_i ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = tms_i ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = tms_i ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = tms_i ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir_q == IrIdcode)     dr_sel = SEL_IDCODE;
    else if (ir_q == IrDtmcs) dr_sel = SEL_DTMCS;
    else if (ir_q == IrDmi)   dr_sel = SEL_DMI;
  end

  assign dtmcs_cap  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, 6'(DmiAbits), 4'd1};
  assign dmi_cap_op = dmi_busy_i ? 2'd3 : dmistat_q;
  assign upd_op     = dr_sr_q[1:0];

  // dmi_req_valid_o is a one-tck pulse with no ready: dmi_busy_i is the only
  // back-pressure, and a request is issued only while it is low and dmistat is clean.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q         <= TLR;
      ir_q            <= IrIdcode;
      ir_sr_q         <= '0;
      dr_sr_q         <= '0;
      dmistat_q       <= '0;
      last_addr_q     <= '0;
      dmi_req_valid_o <= 1'b0;
      dmi_req_addr_o  <= '0;
      dmi_req_data_o  <= '0;
      dmi_req_op_o    <= '0;
      dmi_reset_o     <= 1'b0;
    end else begin
      state_q         <= state_d;
      dmi_req_valid_o <= 1'b0;
      dmi_reset_o     <= 1'b0;
      unique case (state_q)
        CAP_IR: ir_sr_q <= IrLength'(32'h01);
        SH_IR:  ir_sr_q <= {tdi_i, ir_sr_q[IrLength-1:1]};
        UPD_IR: ir_q    <= ir_sr_q;
        CAP_DR: begin
          unique case (dr_sel)
            SEL_IDCODE: dr_sr_q <= DrW'(IdCode);
            SEL_DTMCS:  dr_sr_q <= DrW'(dtmcs_cap);
            SEL_DMI: begin
              dr_sr_q <= {last_addr_q, dmi_resp_data_i, dmi_cap_op};
              if (dmi_busy_i) dmistat_q <= 2'd3;
              else if (dmi_resp_err_i && dmistat_q == 2'd0) dmistat_q <= 2'd2;
            end
            default:    dr_sr_q[0] <= 1'b0;
          endcase
        end
        SH_DR: begin
          unique case (dr_sel)
            SEL_DMI:    dr_sr_q <= {tdi_i, dr_sr_q[DrW-1:1]};
            SEL_BYPASS: dr_sr_q[0] <= tdi_i;
            default: begin
              dr_sr_q[31]   <= tdi_i;
              dr_sr_q[30:0] <= dr_sr_q[31:1];
            end
          endcase
        end
        UPD_DR: begin
          if (dr_sel == SEL_DTMCS) begin
            if (dr_sr_q[16] || dr_sr_q[17]) dmistat_q <= 2'd0;
            if (dr_sr_q[17]) dmi_reset_o <= 1'b1;
          end else if (dr_sel == SEL_DMI) begin
            if (dmi_busy_i) begin
              dmistat_q <= 2'd3;
            end else if (dmistat_q == 2'd0 && (upd_op == 2'd1 || upd_op == 2'd2)) begin
              dmi_req_valid_o <= 1'b1;
              dmi_req_addr_o  <= dr_sr_q[DrW-1:34];
              dmi_req_data_o  <= dr_sr_q[33:2];
              dmi_req_op_o    <= upd_op;
              last_addr_q     <= dr_sr_q[DrW-1:34];
            end
          end
        end
        default: ;
      endcase
      // Entering (or staying in) Test-Logic-Reset wipes the debug-visible state.
      if (state_d == TLR) begin
        ir_q        <= IrIdcode;
        dmistat_q   <= 2'd0;
        last_addr_q <= '0;
      end
    end
  end

  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_oe_o <= (state_q == SH_DR) || (state_q == SH_IR);
      if (state_q == SH_IR)      tdo_o <= ir_sr_q[0];
      else if (state_q == SH_DR) tdo_o <= dr_sr_q[0];
      else                       tdo_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dbg_jtag_tap.sv
// Directed bench for dbg_jtag_tap: drivers push expected TDO bits, DMI requests
// and reset pulses into queues; a monitor pops and compares whenever the DUT presents them.
module tb_dbg_jtag_tap;

  localparam int Abits = 7;
  localparam int DrW   = Abits + 34;
  localparam logic [31:0] Resp = 32'h1234_5678;

  logic             tck_i = 1'b0;
  logic             trst_ni = 1'b0;
  logic             tms_i = 1'b0;
  logic             tdi_i = 1'b0;
  logic             tdo_o, tdo_oe_o;
  logic             dmi_req_valid_o;
  logic [Abits-1:0] dmi_req_addr_o;
  logic [31:0]      dmi_req_data_o;
  logic [1:0]       dmi_req_op_o;
  logic             dmi_busy_i = 1'b0;
  logic [31:0]      dmi_resp_data_i = Resp;
  logic             dmi_resp_err_i = 1'b0;
  logic             dmi_reset_o;
  logic [3:0]       tap_state_o;

  logic [0:0]     tdo_q[$];
  logic [DrW-1:0] req_q[$];
  logic [0:0]     rst_q[$];
  logic [0:0]     exp_bit;
  logic [DrW-1:0] exp_req;
  logic [63:0]    cap;
  int checks = 0;
  int errors = 0;

  dbg_jtag_tap #(.IrLength(5), .IdCode(32'h0000_0DB3), .DmiAbits(Abits)) dut (
    .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .tdi_i(tdi_i),
    .tdo_o(tdo_o), .tdo_oe_o(tdo_oe_o),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_addr_o(dmi_req_addr_o),
    .dmi_req_data_o(dmi_req_data_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_busy_i(dmi_busy_i), .dmi_resp_data_i(dmi_resp_data_i),
    .dmi_resp_err_i(dmi_resp_err_i), .dmi_reset_o(dmi_reset_o),
    .tap_state_o(tap_state_o)
  );

  // clock / watchdog
  initial forever #10 tck_i = ~tck_i;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tck_step(input logic tms, input logic tdi);
    @(negedge tck_i);
    #2;
    tms_i = tms;
    tdi_i = tdi;
    @(posedge tck_i);
    #1;
  endtask

  task automatic scan_ir(input logic [4:0] val);
    tck_step(1'b1, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    tdo_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) tdo_q.push_back(1'b0);
    for (int i = 0; i < 5; i++) tck_step(i == 4, val[i]);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int width, input logic [63:0] din, input logic [63:0] exp);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    for (int i = 0; i < width; i++) tdo_q.push_back(exp[i]);
    for (int i = 0; i < width; i++) tck_step(i == width - 1, din[i]);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(posedge tck_i);
      #1;
      if (trst_ni) begin
        if (tdo_oe_o) begin
          if (tdo_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tdo_unexpected actual=oe high tdo=%b required=oe low", tdo_o);
          end else begin
            exp_bit = tdo_q.pop_front();
            check("tdo_bit", 64'(tdo_o), 64'(exp_bit));
          end
        end
        if (dmi_req_valid_o) begin
          if (req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected actual=addr %h data %h op %0d required=no request",
                     dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o);
          end else begin
            exp_req = req_q.pop_front();
            check("dmi_req", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), 64'(exp_req));
          end
        end
        if (dmi_reset_o) begin
          if (rst_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL dmi_reset_unexpected actual=1 required=0");
          end else begin
            exp_bit = rst_q.pop_front();
            check("dmi_reset", 64'(dmi_reset_o), 64'(exp_bit));
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    trst_ni = 1'b0;
    #25;
    check("rst_tdo", 64'(tdo_o), 64'd0);
    check("rst_tdo_oe", 64'(tdo_oe_o), 64'd0);
    check("rst_req_valid", 64'(dmi_req_valid_o), 64'd0);
    check("rst_req_fields", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}), 64'd0);
    check("rst_dmi_reset", 64'(dmi_reset_o), 64'd0);
    check("rst_state_tlr", 64'(tap_state_o), 64'd0);
    @(negedge tck_i);
    trst_ni = 1'b1;

    // IDCODE straight out of reset: TMS 0,1,0,0 then 32 shifts
    tck_step(1'b0, 1'b0);
    scan_dr(32, 64'h0, 64'h0000_0DB3);

    // BYPASS: output is 0 then TDI delayed one bit
    scan_ir(5'h1F);
    scan_dr(16, 64'h00FF, 64'h01FE);

    // DMI write then a nop that reads back last_addr
    scan_ir(5'h11);
    req_q.push_back({7'h10, 32'h0000_0001, 2'd2});
    scan_dr(DrW, 64'({7'h10, 32'h0000_0001, 2'd2}), 64'({7'h00, Resp, 2'd0}));
    scan_dr(DrW, 64'({7'h05, 32'h0000_DEAD, 2'd0}), 64'({7'h10, Resp, 2'd0}));

    // busy during a DMI scan: sticky dmistat=3, no request
    dmi_busy_i = 1'b1;
    scan_dr(DrW, 64'({7'h22, 32'h0000_CAFE, 2'd2}), 64'({7'h10, Resp, 2'd3}));
    dmi_busy_i = 1'b0;
    scan_ir(5'h10);
    scan_dr(32, 64'h0001_0000, 64'h0000_1C71);
    scan_dr(32, 64'h0, 64'h0000_1071);
    scan_ir(5'h11);
    req_q.push_back({7'h22, 32'h0000_CAFE, 2'd1});
    scan_dr(DrW, 64'({7'h22, 32'h0000_CAFE, 2'd1}), 64'({7'h10, Resp, 2'd0}));

    // dmihardreset pulses dmi_reset_o once; request fields hold
    scan_ir(5'h10);
    rst_q.push_back(1'b1);
    scan_dr(32, 64'h0002_0000, 64'h0000_1071);
    scan_dr(32, 64'h0, 64'h0000_1071);
    check("req_fields_hold", 64'({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o}),
          64'({7'h22, 32'h0000_CAFE, 2'd1}));

    // response error sets dmistat=2, which blocks the following write
    scan_ir(5'h11);
    dmi_resp_err_i = 1'b1;
    scan_dr(DrW, 64'({7'h33, 32'h0000_0001, 2'd2}), 64'({7'h22, Resp, 2'd0}));
    dmi_resp_err_i = 1'b0;
    scan_dr(DrW, 64'h0, 64'({7'h22, Resp, 2'd2}));

    // trst mid-shift of a DMI write: partial shift discarded
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    cap = 64'({7'h22, Resp, 2'd2});
    for (int i = 0; i < 10; i++) tdo_q.push_back(cap[i]);
    for (int i = 0; i < 10; i++) tck_step(1'b0, 1'b1);
    #5;
    trst_ni = 1'b0;
    #1;
    check("midrst_tdo_oe", 64'(tdo_oe_o), 64'd0);
    check("midrst_state_tlr", 64'(tap_state_o), 64'd0);
    @(posedge tck_i);
    @(negedge tck_i);
    trst_ni = 1'b1;
    tck_step(1'b0, 1'b0);
    scan_dr(32, 64'h0, 64'h0000_0DB3);

    // five TMS=1 from PauseIR reach TLR
    tck_step(1'b1, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b1, 1'b0);
    tck_step(1'b0, 1'b0);
    check("state_pause_ir", 64'(tap_state_o), 64'd13);
    for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0);
    check("state_tlr_after_tms", 64'(tap_state_o), 64'd0);

    repeat (3) tck_step(1'b0, 1'b0);
    check("tdo_q_drained", 64'(tdo_q.size()), 64'd0);
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("rst_q_drained", 64'(rst_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
